// File: rtl/tag_state_update.sv
// rtl/tag_state_update.sv - per-set valid/modified/PLRU state owner with update, read and flush sweep
module tag_state_update #(
  parameter int SETS     = 64,
  parameter int SET_BITS = 6
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                rd_en_d,
  input  logic [SET_BITS-1:0] rd_set_d,
  output logic                rd_valid_d,
  output logic [3:0]          val_output_d,
  output logic [3:0]          mod_output_d,
  output logic [2:0]          lru_output_d,
  input  logic                upd_en_d,
  input  logic [SET_BITS-1:0] upd_set_d,
  input  logic [3:0]          upd_way_d,
  input  logic [1:0]          upd_op_d,
  input  logic                upd_dirty_d,
  output logic                upd_err_d,
  input  logic                flush_req_d,
  output logic                flush_busy_d,
  output logic                flush_done_d
);

  typedef enum logic [1:0] {ST_IDLE, ST_SWEEP, ST_DONE} state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [SET_BITS-1:0] r_sweep_idx;
  logic [3:0]          r_val [SETS];
  logic [3:0]          r_mod [SETS];
  logic [2:0]          r_lru [SETS];
  logic                r_rd_valid;
  logic [3:0]          r_val_out;
  logic [3:0]          r_mod_out;
  logic [2:0]          r_lru_out;
  logic                r_upd_err;

  logic                w_idle;
  logic                w_busy;
  logic                w_done;
  logic                w_last_idx;
  logic                w_onehot;
  logic                w_upd_ok;
  logic                w_rd_ok;
  logic                w_fwd;
  logic [3:0]          w_cur_val;
  logic [3:0]          w_cur_mod;
  logic [2:0]          w_cur_lru;
  logic [2:0]          w_touch_lru;
  logic [3:0]          w_new_val;
  logic [3:0]          w_new_mod;
  logic [2:0]          w_new_lru;

  assign w_last_idx = (r_sweep_idx == SET_BITS'(SETS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_idle       = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_idle = 1'b1;
        if (flush_req_d) w_next_state = ST_SWEEP;
      end
      ST_SWEEP: begin
        w_busy = 1'b1;
        if (w_last_idx) w_next_state = ST_DONE;
      end
      ST_DONE: begin
        w_busy       = 1'b1;
        w_done       = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign w_onehot  = (upd_way_d != 4'd0) && ((upd_way_d & (upd_way_d - 4'd1)) == 4'd0);
  assign w_upd_ok  = upd_en_d && w_idle && w_onehot;
  assign w_rd_ok   = rd_en_d && w_idle;
  assign w_fwd     = w_upd_ok && (rd_set_d == upd_set_d);
  assign w_cur_val = r_val[upd_set_d];
  assign w_cur_mod = r_mod[upd_set_d];
  assign w_cur_lru = r_lru[upd_set_d];

  // Point the tree away from the touched way; only the bits on its path change.
  always_comb begin
    w_touch_lru = w_cur_lru;
    if (upd_way_d[3]) begin
      w_touch_lru[2] = 1'b1;
      w_touch_lru[1] = 1'b1;
    end else if (upd_way_d[2]) begin
      w_touch_lru[2] = 1'b1;
      w_touch_lru[1] = 1'b0;
    end else if (upd_way_d[1]) begin
      w_touch_lru[2] = 1'b0;
      w_touch_lru[0] = 1'b1;
    end else begin
      w_touch_lru[2] = 1'b0;
      w_touch_lru[0] = 1'b0;
    end
  end

  always_comb begin
    w_new_val = w_cur_val;
    w_new_mod = w_cur_mod;
    w_new_lru = w_cur_lru;
    case (upd_op_d)
      2'b00: w_new_lru = w_touch_lru;
      2'b01: begin
        w_new_lru = w_touch_lru;
        w_new_mod = w_cur_mod | upd_way_d;
      end
      2'b10: begin
        w_new_lru = w_touch_lru;
        w_new_val = w_cur_val | upd_way_d;
        w_new_mod = upd_dirty_d ? (w_cur_mod | upd_way_d) : (w_cur_mod & ~upd_way_d);
      end
      default: begin
        w_new_val = w_cur_val & ~upd_way_d;
        w_new_mod = w_cur_mod & ~upd_way_d;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SETS; i++) begin
        r_val[i] <= 4'd0;
        r_mod[i] <= 4'd0;
        r_lru[i] <= 3'd0;
      end
    end else if (r_state == ST_SWEEP) begin
      r_val[r_sweep_idx] <= 4'd0;
      r_mod[r_sweep_idx] <= 4'd0;
      r_lru[r_sweep_idx] <= 3'd0;
    end else if (w_upd_ok) begin
      r_val[upd_set_d] <= w_new_val;
      r_mod[upd_set_d] <= w_new_mod;
      r_lru[upd_set_d] <= w_new_lru;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sweep_idx <= '0;
    end else if (r_state == ST_SWEEP) begin
      if (!w_last_idx) r_sweep_idx <= r_sweep_idx + 1'b1;
    end else begin
      r_sweep_idx <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_valid <= 1'b0;
      r_val_out  <= 4'd0;
      r_mod_out  <= 4'd0;
      r_lru_out  <= 3'd0;
      r_upd_err  <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_ok;
      r_upd_err  <= upd_en_d && w_idle && !w_onehot;
      if (w_rd_ok) begin
        r_val_out <= w_fwd ? w_new_val : r_val[rd_set_d];
        r_mod_out <= w_fwd ? w_new_mod : r_mod[rd_set_d];
        r_lru_out <= w_fwd ? w_new_lru : r_lru[rd_set_d];
      end
    end
  end

  assign rd_valid_d   = r_rd_valid;
  assign val_output_d = r_val_out;
  assign mod_output_d = r_mod_out;
  assign lru_output_d = r_lru_out;
  assign upd_err_d    = r_upd_err;
  assign flush_busy_d = w_busy;
  assign flush_done_d = w_done;

endmodule

// File: tb/tb_tag_state_update.sv
// tb/tb_tag_state_update.sv - randomized bench for tag_state_update against a set-array reference model
module tb_tag_state_update;
  localparam int SETS = 64;
  localparam int SB   = 6;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          rd_en_d;
  logic [SB-1:0] rd_set_d;
  logic          rd_valid_d;
  logic [3:0]    val_output_d;
  logic [3:0]    mod_output_d;
  logic [2:0]    lru_output_d;
  logic          upd_en_d;
  logic [SB-1:0] upd_set_d;
  logic [3:0]    upd_way_d;
  logic [1:0]    upd_op_d;
  logic          upd_dirty_d;
  logic          upd_err_d;
  logic          flush_req_d;
  logic          flush_busy_d;
  logic          flush_done_d;

  always #5 clk = ~clk;

  tag_state_update #(.SETS(SETS), .SET_BITS(SB)) dut (
    .clk(clk), .reset_n(reset_n),
    .rd_en_d(rd_en_d), .rd_set_d(rd_set_d), .rd_valid_d(rd_valid_d),
    .val_output_d(val_output_d), .mod_output_d(mod_output_d), .lru_output_d(lru_output_d),
    .upd_en_d(upd_en_d), .upd_set_d(upd_set_d), .upd_way_d(upd_way_d), .upd_op_d(upd_op_d),
    .upd_dirty_d(upd_dirty_d), .upd_err_d(upd_err_d),
    .flush_req_d(flush_req_d), .flush_busy_d(flush_busy_d), .flush_done_d(flush_done_d)
  );

  int checks = 0;
  int errors = 0;

  logic [3:0] m_val [SETS];
  logic [3:0] m_mod [SETS];
  logic [2:0] m_lru [SETS];
  logic [3:0] e_val;
  logic [3:0] e_mod;
  logic [2:0] e_lru;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear;
    for (int i = 0; i < SETS; i++) begin
      m_val[i] = 4'd0;
      m_mod[i] = 4'd0;
      m_lru[i] = 3'd0;
    end
  endtask

  // Victim tree: root bit picks a pair, leaf bit picks within it; touching aims it elsewhere.
  function automatic logic [2:0] touch(input logic [2:0] l, input int w);
    logic [2:0] r;
    r = l;
    case (w)
      3: begin r[2] = 1'b1; r[1] = 1'b1; end
      2: begin r[2] = 1'b1; r[1] = 1'b0; end
      1: begin r[2] = 1'b0; r[0] = 1'b1; end
      default: begin r[2] = 1'b0; r[0] = 1'b0; end
    endcase
    return r;
  endfunction

  function automatic int way_idx(input logic [3:0] w);
    for (int i = 0; i < 4; i++) if (w[i]) return i;
    return 0;
  endfunction

  task automatic model_update(input int s, input logic [3:0] way, input logic [1:0] op, input logic dirty);
    int w;
    w = way_idx(way);
    case (op)
      2'd0: m_lru[s] = touch(m_lru[s], w);
      2'd1: begin m_lru[s] = touch(m_lru[s], w); m_mod[s][w] = 1'b1; end
      2'd2: begin m_lru[s] = touch(m_lru[s], w); m_val[s][w] = 1'b1; m_mod[s][w] = dirty; end
      default: begin m_val[s][w] = 1'b0; m_mod[s][w] = 1'b0; end
    endcase
  endtask

  // One idle-state cycle: optional read and update, then check everything observable.
  task automatic drive(input bit rd, input int rs, input bit up, input int us,
                       input logic [3:0] way, input logic [1:0] op, input logic dirty);
    bit exp_err;
    rd_en_d = rd; rd_set_d = SB'(rs);
    upd_en_d = up; upd_set_d = SB'(us); upd_way_d = way; upd_op_d = op; upd_dirty_d = dirty;
    exp_err = up && ($countones(way) != 1);
    if (up && !exp_err) model_update(us, way, op, dirty);
    if (rd) begin
      e_val = m_val[rs];
      e_mod = m_mod[rs];
      e_lru = m_lru[rs];
    end
    tick;
    rd_en_d = 1'b0;
    upd_en_d = 1'b0;
    check("rd_valid", 32'(rd_valid_d), 32'(rd));
    check("val", 32'(val_output_d), 32'(e_val));
    check("mod", 32'(mod_output_d), 32'(e_mod));
    check("lru", 32'(lru_output_d), 32'(e_lru));
    check("upd_err", 32'(upd_err_d), 32'(exp_err));
  endtask

  initial begin
    int cnt;
    int done_at;
    int done_cnt;
    logic [3:0] way;

    reset_n = 1'b0; rd_en_d = 1'b0; rd_set_d = '0; upd_en_d = 1'b0; upd_set_d = '0;
    upd_way_d = 4'd0; upd_op_d = 2'd0; upd_dirty_d = 1'b0; flush_req_d = 1'b0;
    model_clear();
    e_val = 4'd0; e_mod = 4'd0; e_lru = 3'd0;
    tick; tick;
    check("reset rd_valid", 32'(rd_valid_d), 32'd0);
    check("reset val", 32'(val_output_d), 32'd0);
    check("reset mod", 32'(mod_output_d), 32'd0);
    check("reset lru", 32'(lru_output_d), 32'd0);
    check("reset err", 32'(upd_err_d), 32'd0);
    check("reset busy", 32'(flush_busy_d), 32'd0);
    check("reset done", 32'(flush_done_d), 32'd0);
    reset_n = 1'b1;
    tick;

    drive(1, 5, 0, 0, 4'd0, 2'd0, 1'b0);
    for (int w = 0; w < 4; w++) drive(0, 0, 1, 3, 4'(1 << w), 2'd2, 1'b0);
    drive(1, 3, 0, 0, 4'd0, 2'd0, 1'b0);
    check("fill4 val", 32'(val_output_d), 32'hf);
    drive(1, 3, 1, 3, 4'b0010, 2'd1, 1'b0);
    drive(1, 3, 1, 3, 4'b0010, 2'd3, 1'b0);
    check("inval val", 32'(val_output_d), 32'hd);
    drive(1, 7, 1, 7, 4'b0100, 2'd2, 1'b0);
    check("fwd val", 32'(val_output_d), 32'h4);
    check("fwd lru", 32'(lru_output_d), 32'h4);
    drive(1, 7, 1, 7, 4'b0110, 2'd2, 1'b1);
    drive(0, 0, 0, 0, 4'd0, 2'd0, 1'b0);
    drive(0, 0, 1, 7, 4'b0000, 2'd3, 1'b0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) way = 4'($urandom_range(0, 15));
      else way = 4'(1 << $urandom_range(0, 3));
      drive($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
            way, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    for (int s = 10; s < 14; s++) drive(0, 0, 1, s, 4'b1000, 2'd2, 1'b1);

    flush_req_d = 1'b1;
    upd_en_d = 1'b1; upd_set_d = SB'(9); upd_way_d = 4'b0001; upd_op_d = 2'd2; upd_dirty_d = 1'b1;
    tick;
    flush_req_d = 1'b0;
    upd_en_d = 1'b0;
    check("flush start err", 32'(upd_err_d), 32'd0);
    cnt = 0; done_at = 0; done_cnt = 0;
    while (flush_busy_d && cnt < 200) begin
      cnt++;
      if (flush_done_d) begin done_at = cnt; done_cnt++; end
      if (cnt == 30) begin
        upd_en_d = 1'b1; upd_set_d = SB'(2); upd_way_d = 4'b0011; upd_op_d = 2'd2;
        rd_en_d = 1'b1; rd_set_d = SB'(2); flush_req_d = 1'b1;
      end
      if (cnt == 31) begin
        check("sweep rd_valid", 32'(rd_valid_d), 32'd0);
        check("sweep err", 32'(upd_err_d), 32'd0);
        upd_en_d = 1'b0; rd_en_d = 1'b0; flush_req_d = 1'b0;
      end
      tick;
    end
    check("busy cycles", 32'(cnt), 32'd65);
    check("done cycle", 32'(done_at), 32'd65);
    check("done pulses", 32'(done_cnt), 32'd1);
    model_clear();
    tick;
    check("post busy", 32'(flush_busy_d), 32'd0);
    check("post done", 32'(flush_done_d), 32'd0);
    for (int s = 0; s < SETS; s++) drive(1, s, 0, 0, 4'd0, 2'd0, 1'b0);
    drive(1, 2, 1, 2, 4'b0010, 2'd2, 1'b1);

    flush_req_d = 1'b1;
    tick;
    flush_req_d = 1'b0;
    for (int i = 0; i < 20; i++) tick;
    check("mid busy", 32'(flush_busy_d), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst busy", 32'(flush_busy_d), 32'd0);
    check("rst done", 32'(flush_done_d), 32'd0);
    check("rst rd_valid", 32'(rd_valid_d), 32'd0);
    check("rst val", 32'(val_output_d), 32'd0);
    check("rst mod", 32'(mod_output_d), 32'd0);
    check("rst lru", 32'(lru_output_d), 32'd0);
    model_clear();
    e_val = 4'd0; e_mod = 4'd0; e_lru = 3'd0;
    tick; tick;
    reset_n = 1'b1;
    tick;
    check("rst idle busy", 32'(flush_busy_d), 32'd0);
    drive(1, 2, 0, 0, 4'd0, 2'd0, 1'b0);
    drive(1, 40, 1, 40, 4'b1000, 2'd1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
